frame_stack: RTL and testbench

- LIFO frame store for the recursive Fibonacci datapath; holds pending argument/return frames between recursion steps.
- Sits directly downstream of the Fibonacci controller: consumes its push/pop/top strobes and returns top-of-stack data and the isEmpty status the controller branches on.
- Single-port register-array stack with a registered read port, a stack pointer, status flags and sticky error flags.

---
 rtl/frame_stack.sv | 69 ++++++
 tb/tb_frame_stack.sv | 136 +++++++++++++
 2 files changed

// File: rtl/frame_stack.sv
// frame_stack: LIFO frame store with registered read port, count/status flags and sticky errors.
// Define FRAME_STACK_HWM_EN to add the hwm (high-water mark) output.
module frame_stack #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              top,
  input  logic              clr_err,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              isEmpty,
  output logic              isFull,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
`ifdef FRAME_STACK_HWM_EN
  ,
  output logic [ADDR_W:0]   hwm
`endif
);
  localparam logic [ADDR_W:0] cnt_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] cnt_full = (ADDR_W+1)'(DEPTH);
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   dec, count_next;
  logic [ADDR_W-1:0] tp_a, wr_a;
  logic              ex, do_push, do_pop, ovf_ev, unf_ev, rd, we;
  assign isEmpty = count == '0;
  assign isFull  = count == cnt_full;
  // A full push with top reads mem[DEPTH-1], which is also the count-1 slot.
  always_comb begin
    dec        = count - cnt_one;
    tp_a       = dec[ADDR_W-1:0];
    ex         = push & pop & !isEmpty;
    do_push    = push & !ex & !isFull;
    ovf_ev     = push & !ex & isFull;
    do_pop     = !push & pop & !isEmpty;
    unf_ev     = !push & (pop | top) & isEmpty;
    rd         = ex | (!push & (pop | top) & !isEmpty) | (push & isFull & top);
    we         = !rst & (ex | do_push);
    wr_a       = ex ? tp_a : count[ADDR_W-1:0];
    count_next = do_push ? count + cnt_one : do_pop ? dec : count;
  end
  always_ff @(posedge clk)
    if (we) mem[wr_a] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      dout      <= (do_push & top) ? din : rd ? mem[tp_a] : dout;
      overflow  <= ovf_ev | (overflow & !clr_err);
      underflow <= unf_ev | (underflow & !clr_err);
    end
  end
`ifdef FRAME_STACK_HWM_EN
  always_ff @(posedge clk) begin
    if (rst) hwm <= '0;
    else if (count_next > hwm) hwm <= count_next;
  end
`endif
endmodule

// File: tb/tb_frame_stack.sv
// tb_frame_stack: table-driven vectors through a scoreboard queue plus a random LIFO sequence.
module tb_frame_stack;
  logic       clk = 1'b0;
  logic       rst, push, pop, top, clr_err;
  logic [7:0] din, dout;
  logic       isEmpty, isFull, overflow, underflow;
  logic [4:0] count;
`ifdef FRAME_STACK_HWM_EN
  logic [4:0] hwm;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_stack dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .top(top), .clr_err(clr_err),
    .din(din), .dout(dout), .isEmpty(isEmpty), .isFull(isFull), .count(count),
    .overflow(overflow), .underflow(underflow)
`ifdef FRAME_STACK_HWM_EN
    , .hwm(hwm)
`endif
  );

  typedef struct {
    logic r, ps, pp, tp, ce;
    logic [7:0] d, q;
    logic [4:0] n;
    logic ov, un;
  } vec_t;

  vec_t tv[$];
  vec_t exp_q[$];
  logic [7:0] lifo[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic add(input logic r, ps, pp, tp, ce, input logic [7:0] d, q,
                     input logic [4:0] n, input logic ov, un);
    tv.push_back('{r, ps, pp, tp, ce, d, q, n, ov, un});
  endtask

  task automatic drive(input logic r, ps, pp, tp, ce, input logic [7:0] d);
    @(negedge clk);
    rst = r; push = ps; pop = pp; top = tp; clr_err = ce; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    logic [7:0] v;
    rst = 1'b1; push = 1'b0; pop = 1'b0; top = 1'b0; clr_err = 1'b0; din = '0;
    //   r ps pp tp ce  din    dout  cnt ov un
    add(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'h05, 8'h00, 1, 0, 0);
    add(0, 1, 0, 0, 0, 8'h04, 8'h00, 2, 0, 0);
    add(0, 1, 0, 0, 0, 8'h03, 8'h00, 3, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h03, 2, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h04, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h05, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'h2A, 8'h05, 1, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h2A, 1, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h2A, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h2A, 0, 0, 0);
    for (int k = 0; k < 16; k++) add(0, 1, 0, 0, 0, 8'(k), 8'h2A, 5'(k + 1), 0, 0);
    add(0, 1, 0, 0, 0, 8'hFF, 8'h2A, 16, 1, 0);
    add(0, 1, 0, 1, 0, 8'hFF, 8'h0F, 16, 1, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h0F, 15, 1, 0);
    add(0, 0, 0, 0, 1, 8'h00, 8'h0F, 15, 0, 0);
    add(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'h11, 8'h00, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 1);
    add(0, 0, 1, 0, 1, 8'h00, 8'h11, 0, 0, 1);
    add(0, 0, 0, 0, 1, 8'h00, 8'h11, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'h07, 8'h11, 1, 0, 0);
    add(0, 1, 0, 0, 0, 8'h09, 8'h11, 2, 0, 0);
    add(0, 1, 1, 0, 0, 8'h33, 8'h09, 2, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h33, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h07, 0, 0, 0);
    add(0, 1, 1, 0, 0, 8'h44, 8'h07, 1, 0, 0);
    add(0, 1, 0, 1, 0, 8'h55, 8'h55, 2, 0, 0);
    add(0, 0, 1, 1, 0, 8'h00, 8'h55, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h44, 0, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h44, 0, 0, 1);
    add(0, 0, 0, 0, 1, 8'h00, 8'h44, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'h01, 8'h44, 1, 0, 0);
    add(0, 1, 0, 0, 0, 8'h02, 8'h44, 2, 0, 0);
    add(0, 1, 0, 0, 0, 8'h03, 8'h44, 3, 0, 0);
    add(1, 1, 0, 0, 0, 8'h99, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1);

    for (int i = 0; i < tv.size(); i++) begin
      exp_q.push_back(tv[i]);
      drive(tv[i].r, tv[i].ps, tv[i].pp, tv[i].tp, tv[i].ce, tv[i].d);
      e = exp_q.pop_front();
      chk($sformatf("v%0d dout", i), 32'(dout), 32'(e.q));
      chk($sformatf("v%0d count", i), 32'(count), 32'(e.n));
      chk($sformatf("v%0d isEmpty", i), 32'(isEmpty), 32'(e.n == 0));
      chk($sformatf("v%0d isFull", i), 32'(isFull), 32'(e.n == 16));
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(e.ov));
      chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(e.un));
`ifdef FRAME_STACK_HWM_EN
      if (i == 29) chk("hwm after fill", 32'(hwm), 32'd16);
      if (i == 50) chk("hwm before reset", 32'(hwm), 32'd3);
      if (i == 51) chk("hwm after reset", 32'(hwm), 32'd0);
`endif
    end

    drive(0, 0, 0, 0, 1, 8'h00);
    chk("clr underflow", 32'(underflow), 32'd0);
    for (int k = 0; k < 16; k++) begin
      v = 8'($urandom_range(0, 255));
      lifo.push_back(v);
      drive(0, 1, 0, 0, 0, v);
    end
    chk("random fill isFull", 32'(isFull), 32'd1);
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1, 0, 0, 8'h00);
      chk($sformatf("random pop %0d", k), 32'(dout), 32'(lifo.pop_back()));
    end
    chk("random drain isEmpty", 32'(isEmpty), 32'd1);
    chk("random drain overflow", 32'(overflow), 32'd0);
    drive(0, 0, 0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
